song_sequencer: RTL and testbench

//  Upstream feeder for the note player. Walks one song stored in an external

---
 rtl/song_sequencer_pkg.sv | 25 ++
 rtl/song_sequencer.sv | 125 ++++++++++++
 tb/tb_song_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer and the note player beside it.
// Holds the sequencer state encoding, the note/duration widths and the
// ROM word field positions ({note, duration}, duration in the low bits).
package song_sequencer_pkg;

  // Widths shared with the note player (note_to_load / duration_to_load).
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  // Song ROM word layout: note = [NOTE_MSB:NOTE_LSB], duration = [DUR_MSB:DUR_LSB].
  localparam int ROM_W    = NOTE_W + DUR_W;
  localparam int NOTE_MSB = ROM_W - 1;
  localparam int NOTE_LSB = DUR_W;
  localparam int DUR_MSB  = DUR_W - 1;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/song_sequencer.sv
// Song sequencer: walks one song in an external synchronous ROM and hands each
// {note, duration} entry to the note player, one entry per done_with_note.
// Ports: clk/reset (async active-high); play, song, song_change, note_done in;
//   rom_addr out / rom_data in (1-cycle ROM latency); note_to_load,
//   duration_to_load, load_new_note, song_done out (all registered).
module song_sequencer #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = song_sequencer_pkg::NOTE_W,
  parameter int DUR_W  = song_sequencer_pkg::DUR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song,
  input  logic                     song_change,
  input  logic                     note_done,
  output logic [SONG_W+IDX_W-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note_to_load,
  output logic [DUR_W-1:0]         duration_to_load,
  output logic                     load_new_note,
  output logic                     song_done
);
  import song_sequencer_pkg::*;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  seq_state_t                state_q, state_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic [SONG_W-1:0]         song_q, song_d;
  logic [SONG_W+IDX_W-1:0]   addr_d;
  logic [NOTE_W-1:0]         note_d;
  logic [DUR_W-1:0]          dur_d;
  logic                      load_d;
  logic                      done_d;

  logic [NOTE_W-1:0]         rom_note;
  logic [DUR_W-1:0]          rom_dur;
  logic [IDX_W-1:0]          index_inc;

  assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur   = rom_data[DUR_W-1:0];
  assign index_inc = index_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      index_q          <= '0;
      song_q           <= '0;
      rom_addr         <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      state_q          <= state_d;
      index_q          <= index_d;
      song_q           <= song_d;
      rom_addr         <= addr_d;
      note_to_load     <= note_d;
      duration_to_load <= dur_d;
      load_new_note    <= load_d;
      song_done        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    song_d  = song_q;
    addr_d  = rom_addr;
    note_d  = note_to_load;
    dur_d   = duration_to_load;
    load_d  = 1'b0;
    done_d  = 1'b0;

    // An abort wins over everything else; the last note stays on the outputs.
    if (song_change) begin
      state_d = S_IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            song_d  = song;
            addr_d  = {song, index_q};
            state_d = S_FETCH;
          end
        end
        // Fetch and load ignore play so a ROM read in flight is never dropped.
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (rom_dur == '0) begin
            state_d = S_DONE;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            load_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // A done seen in the load cycle belongs to the previous note.
          if (note_done && play && !load_new_note) begin
            if (index_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              index_d = index_inc;
              addr_d  = {song_q, index_inc};
              state_d = S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          index_d = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: models the song ROM, keeps an
// event-level reference of the expected outputs, and compares every cycle.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        play;
  logic [1:0]  song;
  logic        song_change;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = '0;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        song_done;

  logic [11:0] rom [0:127];
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // Synchronous song ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  song_sequencer #(.SONG_W(2), .IDX_W(5), .NOTE_W(6), .DUR_W(6)) dut (
    .clk              (clk),
    .reset            (rst),
    .play             (play),
    .song             (song),
    .song_change      (song_change),
    .note_done        (note_done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a song is either idle, has a read pending (countdown
  // until the entry is evaluated), is waiting for the player, or is finishing.
  logic [6:0]  m_addr;
  logic [5:0]  m_note, m_dur;
  logic        m_load, m_done;
  int          m_timer;
  bit          m_wait, m_fin;
  logic [4:0]  m_idx;
  logic [1:0]  m_sq;
  logic [11:0] m_w;
  logic        m_nl, m_nd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr = '0; m_note = '0; m_dur = '0; m_load = 0; m_done = 0;
      m_timer = 0; m_wait = 0; m_fin = 0; m_idx = '0; m_sq = '0;
    end else begin
      m_nl = 0;
      m_nd = 0;
      if (song_change) begin
        m_timer = 0; m_wait = 0; m_fin = 0; m_idx = '0;
      end else if (m_fin) begin
        m_nd = 1; m_fin = 0; m_idx = '0;
      end else if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_w = rom[m_addr];
          if (m_w[5:0] == 6'd0) m_fin = 1;
          else begin
            m_note = m_w[11:6]; m_dur = m_w[5:0]; m_nl = 1; m_wait = 1;
          end
        end
      end else if (m_wait) begin
        if (note_done && play && !m_load) begin
          m_wait = 0;
          if (m_idx == 5'd31) m_fin = 1;
          else begin
            m_idx = m_idx + 5'd1; m_addr = {m_sq, m_idx}; m_timer = 2;
          end
        end
      end else if (play) begin
        m_sq = song; m_addr = {song, m_idx}; m_timer = 2;
      end
      m_load = m_nl;
      m_done = m_nd;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (!rst && chk_en) begin
      chk("rom_addr", rom_addr, m_addr);
      chk("note_to_load", note_to_load, m_note);
      chk("duration_to_load", duration_to_load, m_dur);
      chk("load_new_note", load_new_note, m_load);
      chk("song_done", song_done, m_done);
      chk("pulse_exclusive", load_new_note & song_done, 0);
    end
  end

  task automatic wait_load(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (load_new_note) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int loads, cnt, cd;
    bit seen;
    rst = 0; play = 0; song = 0; song_change = 0; note_done = 0;
    for (int i = 0; i < 128; i++) begin
      rom[i] = {6'($urandom), 6'($urandom_range(1, 63))};
      if ((i < 32 || (i >= 64 && i < 96)) && $urandom_range(0, 7) == 0) rom[i][5:0] = 6'd0;
    end
    rom[64] = {6'd33, 6'd7};
    rom[32] = {6'd12, 6'd3};
    rom[33] = {6'd20, 6'd5};
    rom[34] = 12'd0;

    // Reset state.
    #1 rst = 1;
    #2;
    chk("rst_addr", rom_addr, 0);
    chk("rst_note", note_to_load, 0);
    chk("rst_dur", duration_to_load, 0);
    chk("rst_load", load_new_note, 0);
    chk("rst_done", song_done, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;

    // 1: start song 1.
    @(negedge clk); play = 1; song = 1;
    @(posedge clk); #1; chk("t1_addr", rom_addr, 7'h20); chk("t1_noload0", load_new_note, 0);
    @(negedge clk); song = 3;
    @(posedge clk); #1; chk("t1_noload1", load_new_note, 0);
    @(posedge clk); #1;
    chk("t1_load", load_new_note, 1); chk("t1_note", note_to_load, 12); chk("t1_dur", duration_to_load, 3);

    // 2: done in the load cycle is ignored; a later one advances.
    @(negedge clk); note_done = 1;
    @(negedge clk); note_done = 0;
    @(posedge clk); #1; chk("t2_ignored", rom_addr, 7'h20);
    @(negedge clk); note_done = 1;
    @(posedge clk); #1; chk("t2_addr", rom_addr, 7'h21);
    @(negedge clk); note_done = 0;
    @(posedge clk); #1; chk("t2_noload", load_new_note, 0);
    @(posedge clk); #1;
    chk("t2_load", load_new_note, 1); chk("t2_note", note_to_load, 20); chk("t2_dur", duration_to_load, 5);
    @(negedge clk);
    @(negedge clk); note_done = 1;
    @(posedge clk); #1; chk("t2_addr_end", rom_addr, 7'h22);
    @(negedge clk); note_done = 0; play = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; chk("t2_end_noload", load_new_note, 0); chk("t2_end_nodone", song_done, 0);
    @(posedge clk); #1; chk("t2_song_done", song_done, 1);
    @(posedge clk); #1; chk("t2_song_done_off", song_done, 0);

    // 3: pause in WAIT ignores note_done.
    @(negedge clk); play = 1; song = 1;
    wait_load("t3_first_load");
    @(negedge clk); play = 0; note_done = 1;
    @(negedge clk); note_done = 0;
    repeat (4) @(posedge clk);
    #1; chk("t3_paused_addr", rom_addr, 7'h20);
    @(negedge clk); play = 1;
    @(negedge clk); note_done = 1;
    @(negedge clk); note_done = 0;
    wait_load("t3_resume_load");
    chk("t3_resume_addr", rom_addr, 7'h21);
    chk("t3_resume_note", note_to_load, 20);

    // 4: song_change together with note_done.
    @(negedge clk);
    @(negedge clk); note_done = 1; song_change = 1;
    @(negedge clk); note_done = 0; song_change = 0; play = 0; song = 2;
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (load_new_note) cnt++; end
    chk("t4_no_load", cnt, 0);
    chk("t4_note_held", note_to_load, 20);
    @(negedge clk); play = 1;
    @(posedge clk); #1; chk("t4_addr", rom_addr, 7'h40);
    wait_load("t4_load");
    chk("t4_note", note_to_load, 33);
    @(negedge clk); play = 0; song_change = 1;
    @(negedge clk); song_change = 0;

    // 5: song 3 has 32 nonzero entries and ends by index exhaustion.
    @(negedge clk); play = 1; song = 3;
    loads = 0; seen = 0; cd = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      note_done = (cd == 0);
      if (cd >= 0) cd--;
      @(posedge clk); #1;
      if (load_new_note) begin loads++; cd = 2; end
      if (song_done) begin seen = 1; break; end
    end
    chk("t5_loads", loads, 32);
    chk("t5_song_done", seen, 1);
    @(negedge clk); note_done = 0; play = 0; song_change = 1;
    @(negedge clk); song_change = 0;

    // 6: async reset during FETCH.
    @(negedge clk); play = 1; song = 0;
    @(posedge clk); #2 rst = 1;
    #1;
    chk("t6_addr", rom_addr, 0);
    chk("t6_note", note_to_load, 0);
    chk("t6_dur", duration_to_load, 0);
    chk("t6_load", load_new_note, 0);
    chk("t6_done", song_done, 0);
    @(negedge clk); rst = 0; play = 0;
    @(negedge clk); play = 1; song = 1;
    wait_load("t6_load_after_reset");
    @(negedge clk); song = 2;
    @(negedge clk); song = 3;
    @(negedge clk); song = 0;
    @(posedge clk); #1; chk("t6_song_held", rom_addr[6:5], 1);
    @(negedge clk); note_done = 1;
    @(negedge clk); note_done = 0;
    wait_load("t6_advance_load");
    chk("t6_advance_addr", rom_addr, 7'h21);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      play        = ($urandom_range(0, 9) != 0);
      note_done   = ($urandom_range(0, 3) == 0);
      song_change = ($urandom_range(0, 60) == 0);
      song        = 2'($urandom);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
